explosion_scheduler: RTL
========================

EXPLOSION_SCHEDULER -- requirements
Module: explosion_scheduler

Interface
REQ-001 Parameter DEPTH, 4, explosion request queue depth (power of two, 2..8).
REQ-002 Parameter FRAMES_PER_PHASE, 8, frames each animation phase is shown.
REQ-003 Parameter NUM_PHASES, 4, phases per explosion.
REQ-004 Parameter GAP_FRAMES, 2, blank frames between consecutive explosions.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 frame_tick  in  1  one-cycle pulse per VGA frame (end of visible area).
REQ-008 req_valid  in  1  asteroid-destroyed request.
REQ-009 req_h  in  10  explosion centre, horizontal pixel.
REQ-010 req_v  in  10  explosion centre, vertical pixel.
REQ-011 req_ready  out  1  queue can accept a request this cycle.
REQ-012 flush  in  1  drop queue and current explosion.
REQ-013 destroy  out  1  explosion pattern enabled for the renderer.
REQ-014 dH  out  33  active centre H, zero-extended.
REQ-015 dV  out  33  active centre V, zero-extended.
REQ-016 phase  out  2  current animation phase, 0..NUM_PHASES-1.
REQ-017 busy  out  1  explosion playing or queue non-empty.
REQ-018 done  out  1  one-cycle pulse when an explosion completes normally.

Function
REQ-019 Request SHALL be accepted only in a cycle with req_valid=1 and req_ready=1; it is written to the FIFO tail with clamped coordinates.
REQ-020 Clamping SHALL be req_h to 40..599 and req_v to 40..439, so the ±40-pixel pattern stays on screen.
REQ-021 req_ready SHALL equal (count != DEPTH) from registered count; a pop in the same cycle does not make a full queue ready.
REQ-022 Requests not accepted SHALL be dropped by the requester; no internal overflow state.
REQ-023 FSM states SHALL be IDLE, LOAD, PLAY, GAP.
REQ-024 IDLE -> LOAD when queue non-empty; LOAD pops head into dH/dV, clears phase and frame counter, takes exactly one cycle, -> PLAY.
REQ-025 destroy SHALL be 1 only in PLAY; dH/dV/phase SHALL stay stable throughout PLAY.
REQ-026 In PLAY each frame_tick SHALL increment the frame counter; at FRAMES_PER_PHASE-1 the counter wraps to 0 and phase increments.
REQ-027 frame_tick with phase=NUM_PHASES-1 and counter=FRAMES_PER_PHASE-1 SHALL pulse done next cycle and enter GAP.
REQ-028 GAP SHALL count GAP_FRAMES frame_ticks then -> LOAD if queue non-empty, else IDLE; GAP_FRAMES=0 goes directly.
REQ-029 frame_tick in IDLE or LOAD SHALL be ignored.
REQ-030 Simultaneous push and pop SHALL leave count unchanged and both take effect.
REQ-031 flush SHALL, next cycle, empty the queue, force IDLE, clear destroy/phase/busy, without done; a request present in the flush cycle is discarded; flush overrides all events.
REQ-032 busy SHALL equal (state != IDLE) or (count != 0).
REQ-033 FIFO pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-034 On reset: state IDLE, FIFO empty, destroy=0, dH=0, dV=0, phase=0, done=0, busy=0, req_ready=1, counters 0.
REQ-035 Reset mid-explosion SHALL abandon it with no done pulse.

Structure
REQ-036 Shared package SHALL hold the state enum, screen limits (640, 480), pattern radius 40 and clamp bounds.
REQ-037 FIFO SHALL be one sub-module, explosion_fifo (storage, pointers, count, full/empty).
REQ-038 All outputs SHALL be registered.

Verification
REQ-039 One request (100,200), frame_tick every 10 cycles -> destroy high 32 frames, dH=100, dV=200, phase 0..3 every 8 frames, one done.
REQ-040 Request (5,470) -> dH=40, dV=439.
REQ-041 Five back-to-back requests while playing -> four accepted, req_ready low on fifth, played in order with 2-frame gaps.
REQ-042 Full queue, push during LOAD pop -> push rejected, count 3 after.
REQ-043 flush in phase 2 with 2 queued -> next cycle destroy=0, busy=0, no done, no further explosions.
REQ-044 reset mid-PLAY -> all outputs at reset values next cycle, req_ready=1.

Source files
------------

// File: rtl/explosion_scheduler_pkg.sv
// Shared types and screen geometry for the explosion scheduler.
package explosion_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPlay,
    StGap
  } state_e;

  localparam int unsigned CoordW        = 10;
  localparam int unsigned ScreenW       = 640;
  localparam int unsigned ScreenH       = 480;
  localparam int unsigned PatternRadius = 40;

  // Keep the +/-radius pattern fully on screen.
  localparam logic [CoordW-1:0] HMin = CoordW'(PatternRadius);
  localparam logic [CoordW-1:0] HMax = CoordW'(ScreenW - PatternRadius - 1);
  localparam logic [CoordW-1:0] VMin = CoordW'(PatternRadius);
  localparam logic [CoordW-1:0] VMax = CoordW'(ScreenH - PatternRadius - 1);

  function automatic logic [CoordW-1:0] clamp_coord(input logic [CoordW-1:0] val,
                                                    input logic [CoordW-1:0] lo,
                                                    input logic [CoordW-1:0] hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

endpackage

// File: rtl/explosion_fifo.sv
// Request queue: circular buffer with registered pointers and occupancy count.
module explosion_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CntW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign o_rdata   = r_mem[r_rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/explosion_scheduler.sv
// Queues explosion requests and plays them one at a time, paced by frame ticks.
module explosion_scheduler
  import explosion_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned FRAMES_PER_PHASE = 8,
  parameter int unsigned NUM_PHASES       = 4,
  parameter int unsigned GAP_FRAMES       = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_frame_tick,
  input  logic              i_req_valid,
  input  logic [CoordW-1:0] i_req_h,
  input  logic [CoordW-1:0] i_req_v,
  output logic              o_req_ready,
  input  logic              i_flush,
  output logic              o_destroy,
  output logic [32:0]       o_dH,
  output logic [32:0]       o_dV,
  output logic [1:0]        o_phase,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned FrameW = (FRAMES_PER_PHASE > 1) ? $clog2(FRAMES_PER_PHASE) : 1;
  localparam int unsigned GapW   = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;

  localparam logic [FrameW-1:0] FrameLast = FrameW'(FRAMES_PER_PHASE - 1);
  localparam logic [GapW-1:0]   GapLast   = GapW'((GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0);
  localparam logic [1:0]        PhaseLast = 2'(NUM_PHASES - 1);

  state_e              r_state;
  logic                r_destroy;
  logic                r_done;
  logic [1:0]          r_phase;
  logic [FrameW-1:0]   r_frame;
  logic [GapW-1:0]     r_gap;
  logic [CoordW-1:0]   r_dh;
  logic [CoordW-1:0]   r_dv;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [2*CoordW-1:0] w_wdata;
  logic [2*CoordW-1:0] w_rdata;

  // Full comes from the registered count, so a same-cycle pop never frees a slot early.
  assign o_req_ready = ~w_full;
  assign w_push      = i_req_valid & ~w_full & ~i_flush;
  assign w_pop       = (r_state == StLoad) & ~i_flush;
  assign w_wdata     = {clamp_coord(i_req_h, HMin, HMax), clamp_coord(i_req_v, VMin, VMax)};

  explosion_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * CoordW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Playback FSM; every visible output is a register updated here.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_state   <= StIdle;
      r_destroy <= 1'b0;
      r_done    <= 1'b0;
      r_phase   <= '0;
      r_frame   <= '0;
      r_gap     <= '0;
      if (i_reset) begin
        r_dh <= '0;
        r_dv <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!w_empty) r_state <= StLoad;
        end
        StLoad: begin
          r_dh      <= w_rdata[2*CoordW-1:CoordW];
          r_dv      <= w_rdata[CoordW-1:0];
          r_phase   <= '0;
          r_frame   <= '0;
          r_destroy <= 1'b1;
          r_state   <= StPlay;
        end
        StPlay: begin
          if (i_frame_tick) begin
            if (r_frame == FrameLast) begin
              r_frame <= '0;
              if (r_phase == PhaseLast) begin
                r_done    <= 1'b1;
                r_destroy <= 1'b0;
                r_gap     <= '0;
                if (GAP_FRAMES == 0) begin
                  r_state <= w_empty ? StIdle : StLoad;
                end else begin
                  r_state <= StGap;
                end
              end else begin
                r_phase <= r_phase + 2'd1;
              end
            end else begin
              r_frame <= r_frame + FrameW'(1);
            end
          end
        end
        StGap: begin
          if (i_frame_tick) begin
            if (r_gap == GapLast) begin
              r_state <= w_empty ? StIdle : StLoad;
            end else begin
              r_gap <= r_gap + GapW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Busy is decoded from registered state and count only.
  assign o_busy    = (r_state != StIdle) | ~w_empty;
  assign o_destroy = r_destroy;
  assign o_done    = r_done;
  assign o_phase   = r_phase;
  assign o_dH      = {23'd0, r_dh};
  assign o_dV      = {23'd0, r_dv};

endmodule
